// File: rtl/pc_reg.sv
// Program-counter register for the pipelined CPU.
// It holds the current fetch address and loads the next-PC value from the
// next-PC mux when en is high. When en is low, the current address is held,
// which stalls fetch. clr is an asynchronous, active-low reset that forces the
// PC to RESET_VEC straight away, with no clock edge needed.
// data comes directly from the register, so there is no combinational path
// from adr or en to the instruction-memory address.
module pc_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;

    // Next-state select: take the new address when enabled, otherwise hold.
    // adr is passed through at full width, with no masking or alignment.
    always_comb begin
        data_next = data_reg;
        if (en) begin
            data_next = adr;
        end
    end

    // PC register. Reset takes priority over the load enable.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_reg <= RESET_VEC;
        end else begin
            data_reg <= data_next;
        end
    end

    assign data = data_reg;

endmodule

// File: tb/tb_pc_reg.sv
// Scoreboard bench for pc_reg.
// The stimulus process pushes the expected PC value whenever it wants the
// output observed. A separate monitor process pops each entry and compares it
// against data at the same moment.
module tb_pc_reg;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             clr;
    logic             en;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] data;
    logic             clk_run;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    pc_reg #(
        .WIDTH     (WIDTH),
        .RESET_VEC (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .adr  (adr),
        .data (data)
    );

    // Clock with a gate, so that it can be stopped for the no-clock reset check.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Monitor: each queued expectation is compared with the live output.
    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        forever begin
            wait (exp_q.size() > 0);
            e = exp_q.pop_front();
            checks++;
            if (data !== e.exp) begin
                failures++;
                $display("FAIL %s: data=%h required=%h at %0t", e.name, data, e.exp, $time);
            end else begin
                $display("check %s: data=%h expected=%h ok at %0t", e.name, data, e.exp, $time);
            end
        end
    end

    // Queue one expectation, then give the monitor time to sample it before
    // any input changes.
    task automatic expect_pc(input string name, input logic [WIDTH-1:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus.
    initial begin
        clk_run = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        adr     = '0;

        // Reset with the clock stopped.
        #3;
        expect_pc("reset_noclk", 32'h0);

        // Reset dominance: en=1 and adr=5 over 2 edges while clr=0.
        clk_run = 1'b1;
        en      = 1'b1;
        adr     = 32'h5;
        tick();
        expect_pc("rst_dom_edge1", 32'h0);
        tick();
        expect_pc("rst_dom_edge2", 32'h0);

        // Releasing reset does not change data; the load waits for the edge.
        @(negedge clk);
        clr = 1'b1;
        #1;
        expect_pc("release_no_change", 32'h0);
        tick();
        expect_pc("load_5", 32'h5);

        // Async reset of a preloaded PC with the clock stopped.
        @(negedge clk);
        clk_run = 1'b0;
        #20;
        clr = 1'b0;
        #1;
        expect_pc("async_rst_preloaded", 32'h0);
        #10;
        expect_pc("async_rst_hold", 32'h0);
        clr     = 1'b1;
        clk_run = 1'b1;
        tick();
        expect_pc("reload_5", 32'h5);

        // Stall for 3 edges, then load.
        @(negedge clk);
        en  = 1'b0;
        adr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_pc($sformatf("stall_edge%0d", i), 32'h5);
        end
        @(negedge clk);
        en = 1'b1;
        tick();
        expect_pc("load_40", 32'h40);

        // Mid-cycle reset between edges.
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        expect_pc("midcycle_rst", 32'h0);
        tick();
        expect_pc("midcycle_rst_edge", 32'h0);
        @(negedge clk);
        en  = 1'b1;
        adr = 32'h8;
        clr = 1'b1;
        #1;
        expect_pc("release2_no_change", 32'h0);
        tick();
        expect_pc("load_8", 32'h8);

        // Width boundaries on consecutive enabled edges.
        @(negedge clk);
        adr = 32'hFFFF_FFFC;
        tick();
        expect_pc("load_fffffffc", 32'hFFFF_FFFC);
        @(negedge clk);
        adr = 32'hFFFF_FFFF;
        tick();
        expect_pc("load_ffffffff", 32'hFFFF_FFFF);
        @(negedge clk);
        adr = 32'h0;
        tick();
        expect_pc("load_0", 32'h0);
        @(negedge clk);
        adr = 32'hA5A5_5A5A;
        tick();
        expect_pc("load_a5a55a5a", 32'hA5A5_5A5A);
        @(negedge clk);
        en  = 1'b0;
        adr = 32'h1234_5678;
        tick();
        expect_pc("hold_a5a55a5a", 32'hA5A5_5A5A);

        // Let the monitor drain the queue, then report.
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t required=finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
